// File: rtl/colparity_pkg.sv
// -----------------------------------------------------------------------------
// colparity_pkg
// Shared types and helpers for the column-parity (theta) engine.
//   state_e   : engine FSM states
//   addr_w_f  : slice-address width for a given number of slices (minimum 1)
//   idx       : flat bit index of A[x][y] inside a slice word (y*cols + x)
//   nb_dec    : (x-1) mod cols
//   nb_inc    : (x+1) mod cols
// -----------------------------------------------------------------------------
package colparity_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME_RD,
      S_PRIME_CAP,
      S_RD,
      S_WR,
      S_DONE
   } state_e;

   function automatic int addr_w_f(input int lane_w);
      return (lane_w <= 2) ? 1 : $clog2(lane_w);
   endfunction

   function automatic int idx(input int x, input int y, input int cols);
      return y * cols + x;
   endfunction

   function automatic int nb_dec(input int x, input int cols);
      return (x == 0) ? cols - 1 : x - 1;
   endfunction

   function automatic int nb_inc(input int x, input int cols);
      return (x == cols - 1) ? 0 : x + 1;
   endfunction

endpackage

// File: rtl/colparity_theta_slice.sv
// -----------------------------------------------------------------------------
// colparity_theta_slice
// Purely combinational theta step for one slice.
//   slice_in  [ROWS*COLS] : slice read from memory, bit y*COLS+x = A[x][y]
//   c_prev    [COLS]      : column parities of the previous slice (z-1, wrapping)
//   slice_out [ROWS*COLS] : A[x][y] ^ c_cur[x-1] ^ c_prev[x+1]
//   c_cur     [COLS]      : column parities of slice_in
// -----------------------------------------------------------------------------
module colparity_theta_slice
   import colparity_pkg::*;
#(
   parameter int ROWS = 5,
   parameter int COLS = 5
) (
   input  logic [ROWS*COLS-1:0] slice_in,
   input  logic [COLS-1:0]      c_prev,
   output logic [ROWS*COLS-1:0] slice_out,
   output logic [COLS-1:0]      c_cur
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      c_cur = '0;
      for (int x = 0; x < COLS; x++) begin
         for (int y = 0; y < ROWS; y++) begin
            c_cur[x] = c_cur[x] ^ slice_in[idx(x, y, COLS)];
         end
      end
   end

   always_comb begin
      slice_out = '0;
      for (int x = 0; x < COLS; x++) begin
         for (int y = 0; y < ROWS; y++) begin
            slice_out[idx(x, y, COLS)] = slice_in[idx(x, y, COLS)]
                                       ^ c_cur[nb_dec(x, COLS)]
                                       ^ c_prev[nb_inc(x, COLS)];
         end
      end
   end

endmodule

// File: rtl/colparity_theta_engine.sv
// -----------------------------------------------------------------------------
// colparity_theta_engine
// Sweeps a ROWS x COLS x LANE_W state held in an external synchronous-read
// slice memory, applying the theta column-parity mix one slice per two cycles.
// Slice LANE_W-1 is read first to prime c_prev, so slice 0 can be rewritten
// before the last slice is processed (the last slice is still read unmodified).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   start      run request, sampled in IDLE only (wins over abort in IDLE)
//   abort      cancels a run; forces mem_rd/mem_wr/done low in that cycle
//   mem_addr   slice index
//   mem_rd     read strobe, mem_rdata valid the following cycle
//   mem_rdata  slice read data
//   mem_wr     write strobe
//   mem_wdata  transformed slice (combinational from mem_rdata and c_prev)
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a completed run
//
// Optional feature, enabled by defining COLPAR_PARITY_TAP_EN:
//   par_valid  high in WR
//   par_data   column parities of the slice being written
//   par_idx    index of the slice being written
// -----------------------------------------------------------------------------
module colparity_theta_engine
   import colparity_pkg::*;
#(
   parameter int LANE_W = 64,
   parameter int ROWS   = 5,
   parameter int COLS   = 5,
   localparam int ADDR_W  = addr_w_f(LANE_W),
   localparam int SLICE_W = ROWS * COLS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd,
   input  logic [SLICE_W-1:0] mem_rdata,
   output logic               mem_wr,
   output logic [SLICE_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done
`ifdef COLPAR_PARITY_TAP_EN
   ,
   output logic               par_valid,
   output logic [COLS-1:0]    par_data,
   output logic [ADDR_W-1:0]  par_idx
`endif
);

   localparam logic [ADDR_W-1:0] LAST_Z = ADDR_W'(LANE_W - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   z_q, z_d;
   logic [COLS-1:0]     c_prev_q, c_prev_d;
   logic [COLS-1:0]     c_cur;
   logic [SLICE_W-1:0]  slice_out;
   logic                abort_act;

   colparity_theta_slice #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_slice (
      .slice_in  (mem_rdata),
      .c_prev    (c_prev_q),
      .slice_out (slice_out),
      .c_cur     (c_cur)
   );

   // abort only has an effect once a run is in progress
   assign abort_act = abort && (state_q != S_IDLE);

   always_comb begin
      state_d  = state_q;
      z_d      = z_q;
      c_prev_d = c_prev_q;
      unique case (state_q)
         S_IDLE: begin
            z_d = '0;
            if (start) state_d = S_PRIME_RD;
         end
         S_PRIME_RD:  state_d = S_PRIME_CAP;
         S_PRIME_CAP: begin
            // c_cur here is the parity of the original last slice
            c_prev_d = c_cur;
            state_d  = S_RD;
         end
         S_RD:        state_d = S_WR;
         S_WR: begin
            c_prev_d = c_cur;
            if (z_q == LAST_Z) begin
               state_d = S_DONE;
            end else begin
               z_d     = z_q + ADDR_W'(1);
               state_d = S_RD;
            end
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (abort_act) begin
         state_d  = S_IDLE;
         z_d      = z_q;
         c_prev_d = c_prev_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         z_q      <= '0;
         c_prev_q <= '0;
      end else begin
         state_q  <= state_d;
         z_q      <= z_d;
         c_prev_q <= c_prev_d;
      end
   end

   // Moore decodes of state; strobes are suppressed while abort is active
   always_comb begin
      busy      = (state_q != S_IDLE);
      mem_rd    = ((state_q == S_PRIME_RD) || (state_q == S_RD)) && !abort_act;
      mem_wr    = (state_q == S_WR) && !abort_act;
      done      = (state_q == S_DONE) && !abort_act;
      mem_addr  = '0;
      if (state_q == S_PRIME_RD) begin
         mem_addr = LAST_Z;
      end else if ((state_q == S_RD) || (state_q == S_WR)) begin
         mem_addr = z_q;
      end
      mem_wdata = slice_out;
   end

`ifdef COLPAR_PARITY_TAP_EN
   always_comb begin
      par_valid = (state_q == S_WR) && !abort_act;
      par_data  = par_valid ? c_cur : '0;
      par_idx   = par_valid ? z_q   : '0;
   end
`endif

endmodule

// File: tb/tb_colparity_theta_engine.sv
// -----------------------------------------------------------------------------
// tb_colparity_theta_engine
// Three engine instances (LANE_W = 4, 1, 2) with 5x5 slices, each backed by a
// synchronous-read memory model in this bench. Table-driven vectors for the
// LANE_W=4 sweep, hand-written sequences for abort, LANE_W=1 and start held
// high. Slice bit y*5+x = A[x][y]; column x mask = 25'h108421 << x.
// -----------------------------------------------------------------------------
module tb_colparity_theta_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        start4 = 1'b0, abort4 = 1'b0;
   logic        start1 = 1'b0, abort1 = 1'b0;
   logic        start2 = 1'b0, abort2 = 1'b0;
   logic [1:0]  addr4;
   logic [0:0]  addr1, addr2;
   logic        rd4, wr4, busy4, done4;
   logic        rd1, wr1, busy1, done1;
   logic        rd2, wr2, busy2, done2;
   logic [24:0] rdata4, wdata4, rdata1, wdata1, rdata2, wdata2;

   // memory models and bench-side preload port
   logic [24:0] mem [3][4];
   int          wr_cnt [3];
   logic [1:0]  wr_log [8];
   logic        ld_en = 1'b0;
   int          ld_d = 0, ld_a = 0;
   logic [24:0] ld_data = '0;
   logic        clr = 1'b0;

   int errors = 0;
   int checks = 0;

`ifdef COLPAR_PARITY_TAP_EN
   logic        par_valid4, par_valid1, par_valid2;
   logic [4:0]  par_data4, par_data1, par_data2;
   logic [1:0]  par_idx4;
   logic [0:0]  par_idx1, par_idx2;
   int          tap_n;
   logic [1:0]  tap_idx [4];
   logic [4:0]  tap_dat [4];
`endif

   colparity_theta_engine #(.LANE_W(4), .ROWS(5), .COLS(5)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4),
      .mem_addr(addr4), .mem_rd(rd4), .mem_rdata(rdata4),
      .mem_wr(wr4), .mem_wdata(wdata4), .busy(busy4), .done(done4)
`ifdef COLPAR_PARITY_TAP_EN
      , .par_valid(par_valid4), .par_data(par_data4), .par_idx(par_idx4)
`endif
   );

   colparity_theta_engine #(.LANE_W(1), .ROWS(5), .COLS(5)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .mem_addr(addr1), .mem_rd(rd1), .mem_rdata(rdata1),
      .mem_wr(wr1), .mem_wdata(wdata1), .busy(busy1), .done(done1)
`ifdef COLPAR_PARITY_TAP_EN
      , .par_valid(par_valid1), .par_data(par_data1), .par_idx(par_idx1)
`endif
   );

   colparity_theta_engine #(.LANE_W(2), .ROWS(5), .COLS(5)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .mem_addr(addr2), .mem_rd(rd2), .mem_rdata(rdata2),
      .mem_wr(wr2), .mem_wdata(wdata2), .busy(busy2), .done(done2)
`ifdef COLPAR_PARITY_TAP_EN
      , .par_valid(par_valid2), .par_data(par_data2), .par_idx(par_idx2)
`endif
   );

   always @(posedge clk) begin
      if (rd4) rdata4 <= mem[0][addr4];
      if (rd1) rdata1 <= mem[1][addr1];
      if (rd2) rdata2 <= mem[2][addr2];
      if (wr4) begin
         mem[0][addr4] <= wdata4;
         if (wr_cnt[0] < 8) wr_log[wr_cnt[0]] <= addr4;
         wr_cnt[0] <= wr_cnt[0] + 1;
      end
      if (wr1) begin
         mem[1][addr1] <= wdata1;
         wr_cnt[1] <= wr_cnt[1] + 1;
      end
      if (wr2) begin
         mem[2][addr2] <= wdata2;
         wr_cnt[2] <= wr_cnt[2] + 1;
      end
      if (ld_en) mem[ld_d][ld_a] <= ld_data;
      if (clr) begin
         wr_cnt[0] <= 0;
         wr_cnt[1] <= 0;
         wr_cnt[2] <= 0;
      end
   end

`ifdef COLPAR_PARITY_TAP_EN
   always @(negedge clk) begin
      if (clr) begin
         tap_n <= 0;
      end else if (par_valid4) begin
         if (tap_n < 4) begin
            tap_idx[tap_n] <= par_idx4;
            tap_dat[tap_n] <= par_data4;
         end
         tap_n <= tap_n + 1;
      end
   end
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int d, input int a, input logic [24:0] data);
      ld_en = 1'b1; ld_d = d; ld_a = a; ld_data = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic clear_counts();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   // start pulse on the LANE_W=4 engine (optionally with abort in IDLE),
   // then observe cycles 1..14 after the start edge
   task automatic run4(input logic with_abort, output int done_cyc, output int done_cnt,
                       output int busy_cnt, output int busy_first);
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1;
      start4 = 1'b1; abort4 = with_abort;
      @(posedge clk); #1;
      start4 = 1'b0; abort4 = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (busy4) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = c;
         end
         if (done4) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      string           name;
      logic [3:0][24:0] init;   // {s3, s2, s1, s0}
      logic [3:0][24:0] exp;
   } vec_t;

   vec_t vec [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cyc, done_cnt, busy_cnt, busy_first;
      int d_a, d_b, n_done;
      logic busy_c8, busy_c9;
      logic [24:0] snap0, snap1;

      // ---------------- reset ----------------
      rst = 1'b0; clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  busy4, 0);
      check("rst_done",  done4, 0);
      check("rst_rd",    rd4,   0);
      check("rst_wr",    wr4,   0);
      check("rst_addr",  addr4, 0);
      check("rst_busy1", busy1, 0);
      rst = 1'b1; clr = 1'b0;

      // ---------------- LANE_W=4 table ----------------
      vec[0].name = "zeros";
      vec[0].init = {25'h0, 25'h0, 25'h0, 25'h0};
      vec[0].exp  = {25'h0, 25'h0, 25'h0, 25'h0};
      vec[1].name = "s3_bit00";
      vec[1].init = {25'h1, 25'h0, 25'h0, 25'h0};
      vec[1].exp  = {25'h0210843, 25'h0, 25'h0, 25'h1084210};
      vec[2].name = "s1_x2y1";
      vec[2].init = {25'h0, 25'h0, 25'h80, 25'h0};
      vec[2].exp  = {25'h0, 25'h0210842, 25'h0842188, 25'h0};
      vec[3].name = "even_col";
      vec[3].init = {25'h0, 25'h21, 25'h0, 25'h0};
      vec[3].exp  = {25'h0, 25'h21, 25'h0, 25'h0};
      vec[4].name = "all_bit00";
      vec[4].init = {25'h1, 25'h1, 25'h1, 25'h1};
      vec[4].exp  = {25'h1294A53, 25'h1294A53, 25'h1294A53, 25'h1294A53};

      for (int v = 0; v < 5; v++) begin
         for (int z = 0; z < 4; z++) load(0, z, vec[v].init[z]);
         clear_counts();
         run4(1'b0, done_cyc, done_cnt, busy_cnt, busy_first);
         check({vec[v].name, "_done_cyc"},   done_cyc,   11);
         check({vec[v].name, "_done_cnt"},   done_cnt,   1);
         check({vec[v].name, "_busy_cnt"},   busy_cnt,   11);
         check({vec[v].name, "_busy_first"}, busy_first, 1);
         check({vec[v].name, "_wr_cnt"},     wr_cnt[0],  4);
         for (int z = 0; z < 4; z++) begin
            check($sformatf("%s_wr_addr%0d", vec[v].name, z), wr_log[z], z);
            check($sformatf("%s_slice%0d", vec[v].name, z), mem[0][z], vec[v].exp[z]);
         end
`ifdef COLPAR_PARITY_TAP_EN
         if (v == 2) begin
            check("tap_count", tap_n, 4);
            for (int z = 0; z < 4; z++) begin
               check($sformatf("tap_idx%0d", z), tap_idx[z], z);
               check($sformatf("tap_data%0d", z), tap_dat[z], (z == 1) ? 5'b00100 : 5'b00000);
            end
         end
`endif
      end

      // ---------------- LANE_W=1: A[2][3] ----------------
      load(1, 0, 25'h20000);
      clear_counts();
      d_a = -1; n_done = 0;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (done1) begin
            n_done++;
            if (d_a < 0) d_a = c;
         end
         @(posedge clk); #1;
      end
      check("lw1_done_cyc", d_a,       5);
      check("lw1_done_cnt", n_done,    1);
      check("lw1_wr_cnt",   wr_cnt[1], 1);
      check("lw1_slice",    mem[1][0], 25'hA7294A);

      // ---------------- abort in WR of z=1 ----------------
      for (int z = 0; z < 4; z++) load(0, z, 25'h1);
      clear_counts();
      start4 = 1'b1;
      @(posedge clk); #1;          // cycle 1
      start4 = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end                           // cycle 6: WR z=1
      check("abt_pre_wr",   wr4,   1);
      check("abt_pre_addr", addr4, 1);
      abort4 = 1'b1;
      #1;
      check("abt_wr_forced",   wr4,   0);
      check("abt_rd_forced",   rd4,   0);
      check("abt_done_forced", done4, 0);
      @(posedge clk); #1;
      abort4 = 1'b0;
      check("abt_idle", busy4, 0);
      n_done = 0;
      for (int c = 0; c < 6; c++) begin
         if (done4 || busy4) n_done++;
         @(posedge clk); #1;
      end
      check("abt_quiet",  n_done,    0);
      check("abt_wr_cnt", wr_cnt[0], 1);
      check("abt_slice0", mem[0][0], 25'h1294A53);
      check("abt_slice1", mem[0][1], 25'h1);

      // fresh start, with abort also high in IDLE (start wins)
      load(0, 0, 25'h1);
      clear_counts();
      run4(1'b1, done_cyc, done_cnt, busy_cnt, busy_first);
      check("rerun_busy_first", busy_first, 1);
      check("rerun_done_cyc",   done_cyc,   11);
      check("rerun_done_cnt",   done_cnt,   1);
      for (int z = 0; z < 4; z++)
         check($sformatf("rerun_slice%0d", z), mem[0][z], 25'h1294A53);

      // ---------------- LANE_W=2, start held high ----------------
      load(2, 0, 25'h1);
      load(2, 1, 25'h0);
      clear_counts();
      d_a = -1; d_b = -1; n_done = 0;
      busy_c8 = 1'b1; busy_c9 = 1'b0; snap0 = '0; snap1 = '0;
      start2 = 1'b1;
      @(posedge clk); #1;          // cycle 1
      for (int c = 1; c <= 18; c++) begin
         if (done2) begin
            n_done++;
            if (d_a < 0) d_a = c;
            else if (d_b < 0) d_b = c;
         end
         if (c == 8) begin
            busy_c8 = busy2;
            snap0   = mem[2][0];
            snap1   = mem[2][1];
         end
         if (c == 9) begin
            busy_c9 = busy2;
            start2  = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("b2b_done1",     d_a,     7);
      check("b2b_done2",     d_b,     15);
      check("b2b_done_cnt",  n_done,  2);
      check("b2b_idle_gap",  busy_c8, 0);
      check("b2b_restart",   busy_c9, 1);
      check("b2b_r1_slice0", snap0,   25'h0210843);
      check("b2b_r1_slice1", snap1,   25'h1084210);
      check("b2b_r2_slice0", mem[2][0], 25'hC6318D);
      check("b2b_r2_slice1", mem[2][1], 25'h0);
      check("b2b_wr_cnt",    wr_cnt[2], 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
